// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Holds state encodings, control-bundle type and the per-event control presets.
package hazard_ctrl_pkg;

    localparam int unsigned REG_W_DEF = 5;

    localparam logic [REG_W_DEF-1:0] ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_freeze;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{
        pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
        idex_bubble: 1'b0, pipe_freeze: 1'b0
    };

    localparam ctrl_t CTRL_FREEZE = '{
        pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
        idex_bubble: 1'b0, pipe_freeze: 1'b1
    };

    localparam ctrl_t CTRL_RESET = '{
        pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
        idex_bubble: 1'b1, pipe_freeze: 1'b0
    };

    // Unfrozen pipeline: a load-use stall outranks (and suppresses) a taken branch.
    function automatic ctrl_t run_ctrl(input logic lu, input logic br);
        ctrl_t c;
        c = CTRL_DEFAULT;
        if (lu) begin
            c.pc_write    = 1'b0;
            c.ifid_write  = 1'b0;
            c.idex_bubble = 1'b1;
        end else if (br) begin
            c.ifid_flush  = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detector: the load in ID/EX writes a register
// that the instruction in IF/ID reads.
module load_use_detect
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] i_ifid_rs,
    input  logic [REG_W-1:0] i_ifid_rt,
    input  logic [REG_W-1:0] i_idex_rt,
    input  logic             i_idex_memread,
    output logic             o_lu
);

    logic w_rt_nonzero;
    logic w_rt_match;

    assign w_rt_nonzero = (i_idex_rt != REG_W'(ZERO_REG));
    assign w_rt_match   = (i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt);
    assign o_lu         = i_idex_memread && w_rt_nonzero && w_rt_match;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flushes and a
// memory-wait freeze with timeout watchdog and stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_W   = REG_W_DEF,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic             idex_memread_i,
    input  logic             branch_taken_i,
    input  logic             mem_stall_req_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_freeze_o,
    output logic             error_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [1:0]       state_o
);

    localparam int unsigned       WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              r_error;
    logic              w_error_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_lu;
    ctrl_t             w_ctrl;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_lu (
        .i_ifid_rs      (ifid_rs_i),
        .i_ifid_rt      (ifid_rt_i),
        .i_idex_rt      (idex_rt_i),
        .i_idex_memread (idex_memread_i),
        .o_lu           (w_lu)
    );

    // Next-state and control decode; reset overrides the controls last.
    always_comb begin
        w_ctrl      = CTRL_DEFAULT;
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_error_nxt = r_error;

        case (r_state)
            ST_RUN: begin
                if (mem_stall_req_i) begin
                    w_ctrl      = CTRL_FREEZE;
                    w_state_nxt = ST_MEM_WAIT;
                    w_wait_nxt  = '0;
                end else begin
                    w_ctrl = run_ctrl(w_lu, branch_taken_i);
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready_i) begin
                    w_ctrl      = run_ctrl(w_lu, branch_taken_i);
                    w_state_nxt = ST_RUN;
                end else begin
                    w_ctrl = CTRL_FREEZE;
                    if (r_wait_cnt == WAIT_LAST) begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_wait_nxt = r_wait_cnt + WAIT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        if (rst_i) begin
            w_ctrl = CTRL_RESET;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_error     <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_error    <= w_error_nxt;
            // Saturating count of cycles in which the PC was held.
            if (!w_ctrl.pc_write && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign pc_write_o    = w_ctrl.pc_write;
    assign ifid_write_o  = w_ctrl.ifid_write;
    assign ifid_flush_o  = w_ctrl.ifid_flush;
    assign idex_bubble_o = w_ctrl.idex_bubble;
    assign pipe_freeze_o = w_ctrl.pipe_freeze;
    assign error_o       = r_error;
    assign stall_cnt_o   = r_stall_cnt;
    assign state_o       = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// stimulus, all compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TIMEOUT = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [REG_W-1:0] ifid_rs_i;
    logic [REG_W-1:0] ifid_rt_i;
    logic [REG_W-1:0] idex_rt_i;
    logic             idex_memread_i;
    logic             branch_taken_i;
    logic             mem_stall_req_i;
    logic             mem_ready_i;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             pipe_freeze_o;
    logic             error_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [1:0]       state_o;

    int checks   = 0;
    int failures = 0;

    // Model: waiting on memory or not, cycles spent waiting, sticky error, stall count.
    bit m_wait;
    int m_waited;
    bit m_err;
    int m_cnt;
    bit e_pc, e_ifw, e_flush, e_bub, e_frz;

    hazard_ctrl #(
        .REG_W   (REG_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .ifid_rs_i       (ifid_rs_i),
        .ifid_rt_i       (ifid_rt_i),
        .idex_rt_i       (idex_rt_i),
        .idex_memread_i  (idex_memread_i),
        .branch_taken_i  (branch_taken_i),
        .mem_stall_req_i (mem_stall_req_i),
        .mem_ready_i     (mem_ready_i),
        .pc_write_o      (pc_write_o),
        .ifid_write_o    (ifid_write_o),
        .ifid_flush_o    (ifid_flush_o),
        .idex_bubble_o   (idex_bubble_o),
        .pipe_freeze_o   (pipe_freeze_o),
        .error_o         (error_o),
        .stall_cnt_o     (stall_cnt_o),
        .state_o         (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_wait   = 1'b0;
        m_waited = 0;
        m_err    = 1'b0;
        m_cnt    = 0;
    endtask

    // Expected controls from the current inputs and the model's mode.
    task automatic m_outputs();
        bit lu, frz;
        lu  = idex_memread_i && (idex_rt_i != 0) &&
              ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
        frz = m_wait ? !mem_ready_i : mem_stall_req_i;
        {e_pc, e_ifw, e_flush, e_bub, e_frz} = 5'b11000;
        if (rst_i)                   {e_pc, e_ifw, e_flush, e_bub, e_frz} = 5'b00010;
        else if (frz)                {e_pc, e_ifw, e_frz} = 3'b001;
        else if (lu)                 {e_pc, e_ifw, e_bub} = 3'b001;
        else if (branch_taken_i)     e_flush = 1'b1;
    endtask

    task automatic m_edge();
        if (rst_i) begin
            m_reset();
        end else begin
            if (!e_pc && m_cnt < CNT_MAX) m_cnt++;
            if (!m_wait) begin
                if (mem_stall_req_i) begin
                    m_wait   = 1'b1;
                    m_waited = 0;
                end
            end else if (mem_ready_i) begin
                m_wait = 1'b0;
            end else begin
                m_waited++;
                if (m_waited == TIMEOUT) begin
                    m_err  = 1'b1;
                    m_wait = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        m_outputs();
        check($sformatf("%s.pc_write", tag),   32'(pc_write_o),    32'(e_pc));
        check($sformatf("%s.ifid_write", tag), 32'(ifid_write_o),  32'(e_ifw));
        check($sformatf("%s.ifid_flush", tag), 32'(ifid_flush_o),  32'(e_flush));
        check($sformatf("%s.bubble", tag),     32'(idex_bubble_o), 32'(e_bub));
        check($sformatf("%s.freeze", tag),     32'(pipe_freeze_o), 32'(e_frz));
        check($sformatf("%s.state", tag),      32'(state_o),       32'(m_wait));
        check($sformatf("%s.error", tag),      32'(error_o),       32'(m_err));
        check($sformatf("%s.stall_cnt", tag),  32'(stall_cnt_o),   32'(m_cnt));
    endtask

    // Drive one cycle's inputs between edges, check, then advance one clock.
    task automatic step(input string tag, input bit rst, input bit stall, input bit ready,
                        input bit mr, input int irt, input int rs, input int rt, input bit br);
        rst_i           = rst;
        mem_stall_req_i = stall;
        mem_ready_i     = ready;
        idex_memread_i  = mr;
        idex_rt_i       = REG_W'(irt);
        ifid_rs_i       = REG_W'(rs);
        ifid_rt_i       = REG_W'(rt);
        branch_taken_i  = br;
        if (rst) m_reset();
        #1;
        check_all(tag);
        @(posedge clk_i);
        m_edge();
        #1;
    endtask

    initial begin
        m_reset();
        //         tag          rst st rdy mr irt rs rt br
        step("reset0",       1, 0, 0, 0, 0, 0, 0, 0);
        step("reset1",       1, 0, 0, 0, 0, 0, 0, 0);
        step("idle",         0, 0, 0, 0, 0, 0, 0, 0);
        step("lu_rs",        0, 0, 0, 1, 8, 8, 3, 0);
        step("lu_cleared",   0, 0, 0, 0, 8, 8, 3, 0);
        step("lu_rt",        0, 0, 0, 1, 9, 2, 9, 0);
        step("lu_zero_reg",  0, 0, 0, 1, 0, 0, 0, 0);
        step("lu_no_match",  0, 0, 0, 1, 8, 7, 6, 0);
        step("branch",       0, 0, 0, 0, 0, 1, 2, 1);
        step("branch_lu",    0, 0, 0, 1, 4, 4, 1, 1);
        step("mw_enter",     0, 1, 0, 0, 0, 0, 0, 0);
        step("mw_wait1",     0, 0, 0, 0, 0, 0, 0, 0);
        step("mw_wait2",     0, 1, 0, 0, 0, 0, 0, 0);
        step("mw_ready",     0, 0, 1, 0, 0, 0, 0, 0);
        step("mw_after",     0, 0, 0, 0, 0, 0, 0, 0);
        step("prio_all",     0, 1, 0, 1, 5, 5, 0, 1);
        step("prio_ready_lu",0, 0, 1, 1, 5, 5, 0, 1);
        step("prio_after",   0, 0, 0, 0, 0, 0, 0, 1);
        step("to_enter",     0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < int'(TIMEOUT); i++) step("to_wait", 0, 0, 0, 0, 0, 0, 0, 0);
        step("to_run",       0, 0, 0, 0, 0, 0, 0, 1);
        step("to_sticky",    0, 0, 1, 1, 3, 3, 3, 0);
        step("to_reenter",   0, 1, 0, 0, 0, 0, 0, 0);
        step("to_rewait",    0, 0, 0, 0, 0, 0, 0, 0);
        step("async_rst",    1, 0, 0, 1, 6, 6, 6, 1);
        step("rst_hold",     1, 1, 0, 0, 0, 0, 0, 0);
        step("rst_release",  0, 0, 0, 1, 6, 6, 6, 0);

        // Random phase; long enough for the 8-bit stall counter to saturate.
        for (int i = 0; i < 900; i++) begin
            step("rand", 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)),
                 $urandom_range(0, 2) == 0);
        end
        step("final_rst",    1, 0, 0, 0, 0, 0, 0, 0);
        step("final",        0, 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
